// File: rtl/traffic_collision_monitor_pkg.sv
// Shared types and constants for the traffic collision monitor: object-state
// vector layout, transparency colour, screen height and FSM states.
package traffic_collision_monitor_pkg;

    localparam int IMG_ID     = 0;
    localparam int X          = 1;
    localparam int Y          = 2;
    localparam int W          = 3;
    localparam int H          = 4;
    localparam int NUM_FIELDS = 5;
    localparam int FIELD_W    = 11;

    localparam logic [7:0]  MASK_VALUE = 8'h62;
    localparam logic [10:0] SCREEN_H   = 11'd480;

    typedef logic [NUM_FIELDS-1:0][FIELD_W-1:0] obj_state_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT,
        COOLDOWN
    } fsm_state_t;

    function automatic obj_state_t make_obj(input logic [10:0] img_id,
                                            input logic [10:0] x,
                                            input logic [10:0] y,
                                            input logic [10:0] w,
                                            input logic [10:0] h);
        obj_state_t o;
        o[IMG_ID] = img_id;
        o[X]      = x;
        o[Y]      = y;
        o[W]      = w;
        o[H]      = h;
        return o;
    endfunction

endpackage

// File: rtl/traffic_collision_monitor_if.sv
// Sprite-object bus: per-frame object state vectors and per-pixel colours
// produced by the car and player objects.
interface traffic_collision_monitor_if
    import traffic_collision_monitor_pkg::*;
#(
    parameter int NUM_CARS = 4
) ();

    logic       frame_start;
    obj_state_t car_states [NUM_CARS];
    obj_state_t player_state;
    logic [7:0] car_colors [NUM_CARS];
    logic [7:0] player_color;

    modport master (
        output frame_start,
        output car_states,
        output player_state,
        output car_colors,
        output player_color
    );

    modport slave (
        input frame_start,
        input car_states,
        input player_state,
        input car_colors,
        input player_color
    );

endinterface

// File: rtl/traffic_collision_monitor_car_overlap_check.sv
// Combinational bounding-box overlap test between the player and one car.
// Touching edges do not overlap; empty or offscreen cars never overlap.
module car_overlap_check
    import traffic_collision_monitor_pkg::*;
(
    input  obj_state_t player,
    input  obj_state_t car,
    output logic       overlap
);

    logic [11:0] px, py, pw, ph;
    logic [11:0] cx, cy, cw, ch;
    logic        car_valid;
    logic        x_hit;
    logic        y_hit;
    logic        unused_img;

    // Widen to 12 bits so position + size can never wrap.
    assign px = {1'b0, player[X]};
    assign py = {1'b0, player[Y]};
    assign pw = {1'b0, player[W]};
    assign ph = {1'b0, player[H]};
    assign cx = {1'b0, car[X]};
    assign cy = {1'b0, car[Y]};
    assign cw = {1'b0, car[W]};
    assign ch = {1'b0, car[H]};

    assign car_valid = (car[W] != '0) && (car[H] != '0) && (car[Y] < SCREEN_H);
    assign x_hit     = (px < cx + cw) && (cx < px + pw);
    assign y_hit     = (py < cy + ch) && (cy < py + ph);
    assign overlap   = car_valid && x_hit && y_hit;

    assign unused_img = ^{player[IMG_ID], car[IMG_ID]};

endmodule

// File: rtl/traffic_collision_monitor.sv
// Object compositor and player/car collision monitor: pixel hits are gated by
// a bounding-box scan once per frame, one report per crash, then a cooldown.
module traffic_collision_monitor
    import traffic_collision_monitor_pkg::*;
#(
    parameter int NUM_CARS        = 4,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic                         clk,
    input  logic                         resetN,
    traffic_collision_monitor_if.slave   obj,
    output logic [7:0]                   output_color,
    output logic                         draw_request,
    output logic                         collision_pulse,
    output logic [2:0]                   collision_car_id,
    output logic                         crash_active
);

    localparam logic [2:0] LAST_IDX      = 3'(NUM_CARS - 1);
    localparam logic [7:0] COOLDOWN_INIT = 8'(COOLDOWN_FRAMES);

    logic [7:0]          comp_color;
    logic                comp_draw;
    logic [NUM_CARS-1:0] new_hits;
    logic [NUM_CARS-1:0] hit_pending;
    logic [NUM_CARS-1:0] hit_latched;

    fsm_state_t          state;
    obj_state_t          car_snap [NUM_CARS];
    obj_state_t          player_snap;
    obj_state_t          sel_car;
    logic                sel_latched;
    logic                sel_overlap;
    logic [2:0]          scan_idx;
    logic [2:0]          hit_id;
    logic                hit_found;
    logic [7:0]          cooldown_cnt;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        comp_color = MASK_VALUE;
        comp_draw  = 1'b0;
        // Walk from lowest priority up so the highest-priority opaque source wins.
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (obj.car_colors[i] != MASK_VALUE) begin
                comp_color = obj.car_colors[i];
                comp_draw  = 1'b1;
            end
        end
        if (obj.player_color != MASK_VALUE) begin
            comp_color = obj.player_color;
            comp_draw  = 1'b1;
        end
    end

    always_comb begin
        new_hits = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            new_hits[i] = (obj.player_color != MASK_VALUE) &&
                          (obj.car_colors[i] != MASK_VALUE);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            output_color <= MASK_VALUE;
            draw_request <= 1'b0;
        end else begin
            output_color <= comp_color;
            draw_request <= comp_draw;
        end
    end

    // Hits raised in the frame_start cycle belong to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_pending <= '0;
            hit_latched <= '0;
        end else if (obj.frame_start) begin
            hit_latched <= hit_pending;
            hit_pending <= new_hits;
        end else begin
            hit_pending <= hit_pending | new_hits;
        end
    end

    always_comb begin
        sel_car     = '0;
        sel_latched = 1'b0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (scan_idx == 3'(i)) begin
                sel_car     = car_snap[i];
                sel_latched = hit_latched[i];
            end
        end
    end

    car_overlap_check u_overlap (
        .player  (player_snap),
        .car     (sel_car),
        .overlap (sel_overlap)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            scan_idx         <= '0;
            hit_id           <= '0;
            hit_found        <= 1'b0;
            cooldown_cnt     <= '0;
            collision_pulse  <= 1'b0;
            collision_car_id <= '0;
            crash_active     <= 1'b0;
            player_snap      <= '0;
            // NOTE: the snapshot array is a few flops, not a RAM, so it is
            // cleared on reset like every other register.
            for (int i = 0; i < NUM_CARS; i++) begin
                car_snap[i] <= '0;
            end
        end else begin
            collision_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (obj.frame_start) begin
                        for (int i = 0; i < NUM_CARS; i++) begin
                            car_snap[i] <= obj.car_states[i];
                        end
                        player_snap <= obj.player_state;
                        scan_idx    <= '0;
                        hit_found   <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (sel_latched && sel_overlap && !hit_found) begin
                        hit_found <= 1'b1;
                        hit_id    <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= REPORT;
                    end else begin
                        scan_idx <= scan_idx + 3'd1;
                    end
                end
                REPORT: begin
                    if (hit_found) begin
                        collision_pulse  <= 1'b1;
                        collision_car_id <= hit_id;
                        crash_active     <= 1'b1;
                        cooldown_cnt     <= COOLDOWN_INIT;
                        state            <= COOLDOWN;
                    end else begin
                        state <= IDLE;
                    end
                end
                COOLDOWN: begin
                    if (obj.frame_start) begin
                        if (cooldown_cnt <= 8'd1) begin
                            cooldown_cnt <= '0;
                            crash_active <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            cooldown_cnt <= cooldown_cnt - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/traffic_collision_monitor.md
Name: traffic_collision_monitor

Overview:
- Consumer end of the sprite-object interface. Takes the per-frame car state vectors ({img_id, x, y, width, height}, 11 bits each) and per-pixel colours from NUM_CARS traffic objects and the player object.
- Composites the pixel colours using MASK_VALUE transparency.
- Detects pixel-accurate player/car collisions, gated by a bounding-box check.
- Reports one collision event per crash, followed by a frame-counted cooldown. Sits between the object modules and the VGA mux and game-control logic.

Parameters:
NUM_CARS, 4, number of traffic objects monitored (1..8)
COOLDOWN_FRAMES, 60, frames for which further collisions are suppressed after a report (1..255)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of each frame
car_states  in  NUM_CARS x 5 x 11  per-car {img_id, x, y, width, height}
player_state  in  5 x 11  player {img_id, x, y, width, height}
car_colors  in  NUM_CARS x 8  per-car pixel colour for the current pixel
player_color  in  8  player pixel colour for the current pixel
output_color  out  8  composited object colour
draw_request  out  1  output_color is opaque
collision_pulse  out  1  one-cycle crash report
collision_car_id  out  3  index of the reported car
crash_active  out  1  high during cooldown

Behaviour:
- Reset: clock is clk; reset is resetN, asynchronous, active-low. All outputs and state are cleared:
  - output_color=MASK_VALUE, draw_request=0, collision_pulse=0, collision_car_id=0, crash_active=0.
  - FSM=IDLE; hit_pending=0, hit_latched=0, cooldown counter=0.
- Compositor (1-cycle registered latency):
  - Priority is player, then car0, then car1, and so on.
  - The first input not equal to MASK_VALUE drives output_color, with draw_request=1.
  - If every input equals MASK_VALUE: output_color=MASK_VALUE, draw_request=0.
- Pixel hit capture:
  - Each cycle, for each car i: if player_color!=MASK and car_colors[i]!=MASK, set hit_pending[i] (sticky).
- Frame rotation: on every frame_start, in any state:
  - hit_latched <= hit_pending.
  - hit_pending <= 0, except bits being set in that same cycle, which survive into the new frame.
- FSM states IDLE, SCAN, REPORT, COOLDOWN:
  - IDLE: on frame_start (cycle T), snapshot car_states and player_state into registers, clear the index, go to SCAN.
  - SCAN: one car per cycle, indices 0..NUM_CARS-1, cycles T+1..T+NUM_CARS.
    - Car i is a hit if hit_latched[i] AND the AABB overlap of the snapshots is true.
    - The lowest-index hit is recorded.
    - After the last index, go to REPORT.
  - REPORT (cycle T+NUM_CARS+1):
    - If a hit was recorded: collision_pulse=1 for exactly this cycle, collision_car_id=index, crash_active=1, counter=COOLDOWN_FRAMES, go to COOLDOWN.
    - Otherwise go to IDLE, with no pulse.
  - COOLDOWN:
    - Each frame_start decrements the counter.
    - When the counter reaches 0, crash_active drops in the same cycle and the FSM goes to IDLE.
    - No scan is started by that frame_start.
    - Hits accumulated during cooldown are discarded by normal rotation.
  - frame_start while in SCAN or REPORT: the snapshot is not retaken; rotation still happens.
- AABB overlap:
  - Overlap is px < cx+cw AND cx < px+pw AND py < cy+ch AND cy < py+ph.
  - Sums are computed unsigned at 12 bits, so there is no wrap.
  - Edges that only touch do not overlap.
  - Cars with width==0, height==0 or y>=SCREEN_H never overlap.
- collision_car_id holds its value until the next report.

Decomposition:
- Package: field indices (IMG_ID=0, X=1, Y=2, W=3, H=4), MASK_VALUE=8'h62, SCREEN_H=480, the 5x11 object-state typedef, and the FSM state enum.
- Sub-module: car_overlap_check, combinational AABB test of two object-state vectors, including the zero-size and offscreen exclusion.

Test Plan:
- Reset check: assert resetN low mid-frame -> output_color=8'h62, draw_request=0, collision_pulse=0, crash_active=0, collision_car_id=0, FSM in IDLE.
- Compositor priority:
  - player=62, car0=62, car1=1f -> next cycle output_color=1f, draw_request=1.
  - player=ff, car1=1f -> next cycle output_color=ff.
  - All inputs 62 -> draw_request=0.
- Collision report:
  - Setup: NUM_CARS=4; player (x256, y380, w64, h128); car2 (x260, y300, w64, h128).
  - Stimulus: one cycle with player_color=ff and car2 colour=91 in frame N; frame_start at cycle T.
  - Required: collision_pulse high only at T+5, collision_car_id=2, crash_active=1.
- AABB gate: same pixel hit but car2 x=320, exactly touching px+pw -> no pulse; car2 width=0 -> no pulse.
- Cooldown: COOLDOWN_FRAMES=3; after a report, hits in the next 3 frames -> no pulse; crash_active falls on the 3rd frame_start; a hit in the following frame -> pulse.
- Reset mid-SCAN: assert resetN low at T+2 -> no pulse, hit_pending/hit_latched cleared; a following frame with no hits -> no pulse.
